// File: rtl/ll_cmd_issuer.sv
// Button/switch front end for the linked-list engine: synchronizes and debounces
// four buttons, frames one opcode pulse per press and latches sticky list errors.
module ll_cmd_issuer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        btn,
  input  logic [DATA_W-1:0] sw,
  input  logic              overflow,
  input  logic              underflow,
  output logic [2:0]        operation,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err_of,
  output logic              err_uf,
  output logic [7:0]        cmd_count
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PH_MAX = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_RELEASE
  } state_t;

  typedef enum logic [2:0] {
    OP_IDLE        = 3'b000,
    OP_INSERT_HEAD = 3'b100,
    OP_INSERT_TAIL = 3'b101,
    OP_DELETE      = 3'b110,
    OP_TRAVERSE    = 3'b111
  } op_t;

  logic [3:0]        btn_meta, btn_sync;
  logic [DATA_W-1:0] sw_meta, sw_sync;
  logic [CNT_W-1:0]  db_cnt [4];
  logic [3:0]        stable, stable_d, press;

  state_t            state, state_nx;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [2:0]        op_nx, sel_op;
  logic [DATA_W-1:0] data_nx;
  logic              of_nx, uf_nx;
  logic [7:0]        count_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  // A button is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
      stable   <= '0;
      stable_d <= '0;
    end else begin
      stable_d <= stable;
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  always_comb begin
    sel_op = OP_IDLE;
    if (press[0])      sel_op = OP_INSERT_HEAD;
    else if (press[1]) sel_op = OP_INSERT_TAIL;
    else if (press[2]) sel_op = OP_DELETE;
    else if (press[3]) sel_op = OP_TRAVERSE;
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    op_nx    = operation;
    data_nx  = data_out;
    of_nx    = err_of;
    uf_nx    = err_uf;
    count_nx = cmd_count;
    case (state)
      S_IDLE: begin
        if (|press) begin
          state_nx = S_ISSUE;
          phase_nx = '0;
          op_nx    = sel_op;
          data_nx  = sw_sync;
          of_nx    = 1'b0;
          uf_nx    = 1'b0;
          count_nx = cmd_count + 8'd1;
        end
      end
      S_ISSUE: begin
        if (overflow)  of_nx = 1'b1;
        if (underflow) uf_nx = 1'b1;
        if (phase == PULSE_LAST) begin
          state_nx = S_HOLD;
          phase_nx = '0;
          op_nx    = OP_IDLE;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      S_HOLD: begin
        if (overflow)  of_nx = 1'b1;
        if (underflow) uf_nx = 1'b1;
        if (phase == HOLD_LAST) begin
          state_nx = S_RELEASE;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      S_RELEASE: begin
        if (stable == 4'b0000) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // operation is a register cleared by the async reset, so a reset mid-pulse drops it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      operation <= OP_IDLE;
      data_out  <= '0;
      err_of    <= 1'b0;
      err_uf    <= 1'b0;
      cmd_count <= '0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      operation <= op_nx;
      data_out  <= data_nx;
      err_of    <= of_nx;
      err_uf    <= uf_nx;
      cmd_count <= count_nx;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ll_cmd_issuer.sv
// Randomized scoreboard bench for ll_cmd_issuer: stimulus predicts each command
// from the button/switch rules, a monitor checks every opcode frame it observes.
module tb_ll_cmd_issuer;

  localparam int unsigned DEB      = 4;
  localparam int unsigned PULSE    = 2;
  localparam int unsigned HOLD     = 16;
  localparam int unsigned LAT      = 2 + DEB + 1;
  localparam int          FLAG_WIN = PULSE + HOLD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [7:0] sw = 8'h00;
  logic       overflow = 1'b0;
  logic       underflow = 1'b0;
  logic [2:0] operation;
  logic [7:0] data_out;
  logic       busy, err_of, err_uf;
  logic [7:0] cmd_count;

  ll_cmd_issuer #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES(PULSE),
    .HOLD_CYCLES(HOLD),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .sw(sw),
    .overflow(overflow),
    .underflow(underflow),
    .operation(operation),
    .data_out(data_out),
    .busy(busy),
    .err_of(err_of),
    .err_uf(err_uf),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] count;
    logic       eo;
    logic       eu;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_count = 8'd0;
  logic       m_eo = 1'b0;
  logic       m_eu = 1'b0;
  int         ncmd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2:0] exp_op(input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) return 3'(4 + i);
    return 3'b000;
  endfunction

  // Bounce runs are always shorter than the debounce window; ends with a clean low.
  task automatic bounce(input logic [3:0] mask, input int mode);
    int t;
    int r;
    bit hi;
    t = 0;
    hi = 1'b1;
    while (t < 20) begin
      r = (mode == 1) ? 2 : int'($urandom_range(1, DEB - 1));
      btn = hi ? mask : 4'b0;
      repeat (r) @(negedge clk);
      t += r;
      hi = !hi;
    end
    btn = 4'b0;
    repeat (DEB) @(negedge clk);
  endtask

  task automatic glitch_only(input logic [3:0] mask);
    bounce(mask, 2);
    repeat (10) @(negedge clk);
    check("glitch_count", cmd_count, m_count);
  endtask

  task automatic run_cmd(input logic [3:0] mask, input logic [7:0] swv, input int bmode,
                         input int of_k, input int uf_k, input logic [3:0] extra,
                         input bit do_reset);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    sw = swv;
    if (bmode != 0) bounce(mask, bmode);
    if (!do_reset) begin
      m_count = m_count + 8'd1;
      e.op    = exp_op(mask);
      e.data  = swv;
      e.count = m_count;
      e.eo    = (of_k >= 0) && (of_k < FLAG_WIN);
      e.eu    = (uf_k >= 0) && (uf_k < FLAG_WIN);
      expq.push_back(e);
    end
    @(negedge clk);
    btn = mask;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (operation != 3'b000) seen = 1'b1;
    end
    check("cmd_start", seen, 1);
    if (seen) check("press_latency", n, LAT);
    if (do_reset) begin
      rst_n = 1'b0;
      btn = 4'b0;
      #1;
      check("reset_op", operation, 0);
      check("reset_busy", busy, 0);
      check("reset_data", data_out, 0);
      m_count = 8'd0;
      m_eo = 1'b0;
      m_eu = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (40) begin
        @(negedge clk);
        if (operation != 3'b000) n++;
      end
      check("no_resume", n, 0);
      check("count_after_reset", cmd_count, m_count);
      return;
    end
    for (int k = 0; k < 24; k++) begin
      overflow  = (k == of_k);
      underflow = (k == uf_k);
      if (k == 11) sw = 8'($urandom);
      if (extra != 4'b0) begin
        if (k == 3)  btn = mask & ~extra;
        if (k == 10) btn = mask | extra;
      end
      @(posedge clk);
      #1;
    end
    overflow = 1'b0;
    underflow = 1'b0;
    btn = 4'b0;
    m_eo = e.eo;
    m_eu = e.eu;
    repeat (20) @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    underflow = $urandom_range(0, 1) == 1;
    @(negedge clk);
    underflow = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_err_of", err_of, m_eo);
    check("idle_err_uf", err_uf, m_eu);
  endtask

  // Monitor: one popped expectation per observed opcode frame.
  exp_t cur;
  int   run = 0;
  int   idle_run = 1000;
  bit   in_pulse = 1'b0;
  bit   in_cmd = 1'b0;
  logic prev_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 1'b0;
        in_cmd = 1'b0;
        prev_busy = 1'b0;
        run = 0;
        idle_run = 1000;
      end else begin
        if (operation != 3'b000) begin
          if (!in_pulse) begin
            check("hold_gap", idle_run >= int'(HOLD), 1);
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_cmd actual op=%0b required none", operation);
            end else begin
              cur = expq.pop_front();
              in_cmd = 1'b1;
              check("opcode", operation, cur.op);
              check("data_out", data_out, cur.data);
              check("cmd_count", cmd_count, cur.count);
              check("busy_at_start", busy, 1);
              check("err_of_cleared", err_of, 0);
              check("err_uf_cleared", err_uf, 0);
            end
            in_pulse = 1'b1;
            run = 1;
          end else begin
            run++;
            check("opcode_hold", operation, cur.op);
          end
        end else begin
          if (in_pulse) begin
            check("pulse_len", run, PULSE);
            in_pulse = 1'b0;
            idle_run = 1;
          end else begin
            idle_run++;
          end
        end
        if (prev_busy && !busy && in_cmd) begin
          check("err_of_sticky", err_of, cur.eo);
          check("err_uf_sticky", err_uf, cur.eu);
          check("data_held", data_out, cur.data);
          in_cmd = 1'b0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] mask;
    logic [3:0] extra;
    int         of_k;
    int         uf_k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_operation", operation, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err_of", err_of, 0);
    check("rst_err_uf", err_uf, 0);
    check("rst_cmd_count", cmd_count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_cmd(4'b0001, 8'h11, 0, -1, -1, 4'b0000, 1'b0);
    run_cmd(4'b0010, 8'($urandom), 1, -1, -1, 4'b0000, 1'b0);
    run_cmd(4'b1100, 8'($urandom), 0, -1, -1, 4'b1000, 1'b0);
    run_cmd(4'b0100, 8'hFF, 0, -1, 5, 4'b0000, 1'b0);
    run_cmd(4'b1000, 8'($urandom), 0, FLAG_WIN - 1, FLAG_WIN, 4'b0000, 1'b0);
    run_cmd(4'b0001, 8'($urandom), 0, FLAG_WIN, FLAG_WIN - 1, 4'b0000, 1'b0);
    glitch_only(4'b0010);
    run_cmd(4'b0010, 8'($urandom), 0, -1, -1, 4'b0000, 1'b1);

    ncmd = 0;
    while (ncmd < 256) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch_only(4'($urandom_range(1, 15)));
      end else begin
        mask  = 4'($urandom_range(1, 15));
        extra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        of_k  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 23));
        uf_k  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 23));
        run_cmd(mask, 8'($urandom), int'($urandom_range(0, 2)), of_k, uf_k, extra, 1'b0);
        ncmd++;
      end
    end
    check("count_wrap", cmd_count, m_count);
    repeat (5) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
